mu0_control: RTL and testbench

//  MU0 control unit: fetch/execute FSM that drives the enables of the 16-bit datapath

---
 rtl/mu0_control_pkg.sv | 37 +++
 rtl/mu0_control_if.sv | 35 +++
 rtl/mu0_wait_timer.sv | 40 ++++
 rtl/mu0_control.sv | 137 +++++++++++++
 tb/tb_mu0_control.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mu0_control_pkg.sv
// MU0 control shared definitions: opcodes, ALU function codes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mu0_control_pkg;

  // Opcodes carried in IR[15:12]
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // ALU function select driven on M
  typedef enum logic [1:0] {
    M_Y   = 2'b00,
    M_ADD = 2'b01,
    M_INC = 2'b10,
    M_SUB = 2'b11
  } alu_m_t;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  // Opcodes whose execute phase is a memory access (waits on Mem_Rdy)
  function automatic logic is_mem_op(input logic [3:0] f);
    return (f == OP_LDA) || (f == OP_STO) || (f == OP_ADD) || (f == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_control_if.sv
// MU0 control <-> datapath/memory bundle: status inputs and control outputs.
// Latency: wires only.
// Backpressure: Mem_Rdy stalls the control unit during Rd/Wr cycles.
interface mu0_control_if;
  import mu0_control_pkg::*;

  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       Mem_Rdy;
  logic       X_sel;
  logic       Y_sel;
  logic       Addr_sel;
  alu_m_t     M;
  logic       PC_En;
  logic       ACC_En;
  logic       IR_En;
  logic       Rd;
  logic       Wr;
  logic       Halted;
  logic       Err;

  // Control unit side
  modport master (
    input  F, N, Z, Mem_Rdy,
    output X_sel, Y_sel, Addr_sel, M, PC_En, ACC_En, IR_En, Rd, Wr, Halted, Err
  );

  // Datapath / memory side
  modport slave (
    output F, N, Z, Mem_Rdy,
    input  X_sel, Y_sel, Addr_sel, M, PC_En, ACC_En, IR_En, Rd, Wr, Halted, Err
  );

endinterface

// File: rtl/mu0_wait_timer.sv
// Memory wait counter: counts stalled cycles, flags when TIMEOUT is reached.
// Latency: expired reflects the registered count (1 cycle after the last inc).
// Backpressure: none; clr wins over inc, count holds once expired.
module mu0_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clk,
  input  logic nReset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT));

  // Next count: clear on request, otherwise step while not yet expired
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute control FSM with Mem_Rdy wait, timeout and sticky halt/error.
// Latency: outputs combinational from state/F/N/Z/Mem_Rdy; state moves on each Clk edge.
// Backpressure: FETCH and memory EXEC hold until Mem_Rdy or the wait timer expires.
module mu0_control #(
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          nReset,
  mu0_control_if.master bus
);
  import mu0_control_pkg::*;

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   waiting;
  logic   expired;
  logic   tmr_clr;
  logic   tmr_inc;

  // Cycles that are blocked on a memory handshake
  assign waiting = (state_q == S_FETCH) ||
                   ((state_q == S_EXEC) && is_mem_op(bus.F));

  // Any state change restarts the wait count; idle states keep it at zero
  assign tmr_clr = (state_d != state_q) || !waiting;
  assign tmr_inc = waiting && !bus.Mem_Rdy;

  mu0_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .Clk     (Clk),
    .nReset  (nReset),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (expired)
  );

  // State and sticky error register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode; timeout takes priority over a late Mem_Rdy
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (expired) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (bus.Mem_Rdy) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op(bus.F)) begin
          if (expired) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else if (bus.Mem_Rdy) begin
            state_d = S_FETCH;
          end
        end else if (bus.F == OP_STP) begin
          state_d = S_HALT;
        end else if (bus.F > OP_STP) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; enables gated off in the cycle the wait timer expires
  always_comb begin
    bus.X_sel    = 1'b0;
    bus.Y_sel    = 1'b0;
    bus.Addr_sel = 1'b0;
    bus.M        = M_Y;
    bus.PC_En    = 1'b0;
    bus.ACC_En   = 1'b0;
    bus.IR_En    = 1'b0;
    bus.Rd       = 1'b0;
    bus.Wr       = 1'b0;
    bus.Halted   = 1'b0;
    bus.Err      = err_q;
    unique case (state_q)
      S_FETCH: begin
        bus.Rd    = 1'b1;
        bus.X_sel = 1'b1;
        bus.M     = M_INC;
        bus.IR_En = bus.Mem_Rdy && !expired;
        bus.PC_En = bus.Mem_Rdy && !expired;
      end
      S_EXEC: begin
        unique case (bus.F)
          OP_LDA: begin
            bus.Addr_sel = 1'b1;
            bus.Rd       = 1'b1;
            bus.M        = M_Y;
            bus.ACC_En   = bus.Mem_Rdy && !expired;
          end
          OP_STO: begin
            bus.Addr_sel = 1'b1;
            bus.Wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.Addr_sel = 1'b1;
            bus.Rd       = 1'b1;
            bus.M        = (bus.F == OP_ADD) ? M_ADD : M_SUB;
            bus.ACC_En   = bus.Mem_Rdy && !expired;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            if ((bus.F == OP_JMP) || ((bus.F == OP_JGE) && !bus.N) ||
                ((bus.F == OP_JNE) && !bus.Z)) begin
              bus.Y_sel = 1'b1;
              bus.PC_En = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_HALT:  bus.Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: scoreboarded output vectors checked mid-cycle.
// Latency: one step per clock; outputs sampled 1 ns after the falling edge.
// Backpressure: Mem_Rdy driven per step to exercise waits and timeout.
module tb_mu0_control;
  import mu0_control_pkg::*;

  logic clk;
  logic n_reset;
  int   checks;
  int   errors;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  mu0_control_if bus();

  mu0_control #(.TIMEOUT(15)) dut (
    .Clk    (clk),
    .nReset (n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {X_sel,Y_sel,Addr_sel,M,PC_En,ACC_En,IR_En,Rd,Wr,Halted,Err}
  function automatic logic [11:0] ov(input logic xs, input logic ys, input logic as,
                                     input logic [1:0] m, input logic pc, input logic acc,
                                     input logic ir, input logic rd, input logic wr,
                                     input logic h, input logic e);
    return {xs, ys, as, m, pc, acc, ir, rd, wr, h, e};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.X_sel, bus.Y_sel, bus.Addr_sel, bus.M, bus.PC_En, bus.ACC_En,
            bus.IR_En, bus.Rd, bus.Wr, bus.Halted, bus.Err};
  endfunction

  // Pop the oldest expectation and compare it with the live outputs
  task automatic check_out();
    logic [11:0] e;
    string       t;
    logic [11:0] o;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  // One clock: drive inputs after the falling edge, push expectation, sample
  task automatic step(input string tag, input logic [3:0] f, input logic n,
                      input logic z, input logic rdy, input logic [11:0] e);
    @(negedge clk);
    bus.F       = f;
    bus.N       = n;
    bus.Z       = z;
    bus.Mem_Rdy = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_out();
  endtask

  // Asynchronous reset pulse inside the current cycle, released before the next edge
  task automatic pulse_reset(input string tag);
    #1;
    n_reset = 1'b0;
    exp_q.push_back(12'b0);
    tag_q.push_back(tag);
    #1;
    check_out();
    #1;
    n_reset = 1'b1;
  endtask

  logic [11:0] fetch_wait;
  logic [11:0] fetch_rdy;
  logic [11:0] quiet;
  logic [11:0] halt_ok;
  logic [11:0] halt_err;
  logic [11:0] jump_taken;

  initial begin
    checks      = 0;
    errors      = 0;
    n_reset     = 1'b1;
    bus.F       = 4'h0;
    bus.N       = 1'b0;
    bus.Z       = 1'b0;
    bus.Mem_Rdy = 1'b0;

    fetch_wait = ov(1, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0, 0);
    fetch_rdy  = ov(1, 0, 0, 2'b10, 1, 0, 1, 1, 0, 0, 0);
    quiet      = 12'b0;
    halt_ok    = ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    halt_err   = ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    jump_taken = ov(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);

    pulse_reset("reset_idle");

    // Fetch stalled three cycles, then LDA stalled one cycle
    for (int i = 0; i < 3; i++) step("fetch_wait", OP_LDA, 0, 0, 0, fetch_wait);
    step("fetch_rdy", OP_LDA, 0, 0, 1, fetch_rdy);
    step("lda_wait", OP_LDA, 0, 0, 0, ov(0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0));
    step("lda_rdy", OP_LDA, 0, 0, 1, ov(0, 0, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0));

    // Conditional and unconditional jumps
    step("fetch_jge1", OP_JGE, 1, 0, 1, fetch_rdy);
    step("jge_n1", OP_JGE, 1, 0, 1, quiet);
    step("fetch_jge0", OP_JGE, 0, 0, 1, fetch_rdy);
    step("jge_n0", OP_JGE, 0, 0, 0, jump_taken);
    step("fetch_jne1", OP_JNE, 0, 1, 1, fetch_rdy);
    step("jne_z1", OP_JNE, 0, 1, 1, quiet);
    step("fetch_jne0", OP_JNE, 0, 0, 1, fetch_rdy);
    step("jne_z0", OP_JNE, 1, 0, 0, jump_taken);
    step("fetch_jmp", OP_JMP, 1, 1, 1, fetch_rdy);
    step("jmp", OP_JMP, 1, 1, 0, jump_taken);

    // Store, add, subtract
    step("fetch_sto", OP_STO, 0, 0, 1, fetch_rdy);
    step("sto_wait", OP_STO, 0, 0, 0, ov(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    step("sto_rdy", OP_STO, 0, 0, 1, ov(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    step("fetch_add", OP_ADD, 0, 0, 1, fetch_rdy);
    step("add_rdy", OP_ADD, 0, 0, 1, ov(0, 0, 1, 2'b01, 0, 1, 0, 1, 0, 0, 0));
    step("fetch_sub", OP_SUB, 0, 0, 1, fetch_rdy);
    step("sub_wait", OP_SUB, 0, 0, 0, ov(0, 0, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0));
    step("sub_rdy", OP_SUB, 0, 0, 1, ov(0, 0, 1, 2'b11, 0, 1, 0, 1, 0, 0, 0));

    // Reset in the middle of an LDA execute, then restart into fetch
    step("fetch_lda2", OP_LDA, 0, 0, 1, fetch_rdy);
    step("lda2_wait", OP_LDA, 0, 0, 0, ov(0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0));
    pulse_reset("reset_mid_exec");
    step("fetch_after_reset", OP_STP, 0, 0, 1, fetch_rdy);

    // STP halts cleanly and ignores Mem_Rdy
    step("stp_exec", OP_STP, 0, 0, 1, quiet);
    for (int i = 0; i < 20; i++) step("stp_halt", OP_STP, 0, 0, 1'(i % 2), halt_ok);

    // Illegal opcode halts with Err
    pulse_reset("reset_before_illegal");
    step("fetch_illegal", 4'hA, 0, 0, 1, fetch_rdy);
    step("illegal_exec", 4'hA, 0, 0, 1, quiet);
    for (int i = 0; i < 3; i++) step("illegal_halt", 4'hA, 0, 0, 1'(i % 2), halt_err);

    // Fetch timeout: 15 stalled cycles, then a late Mem_Rdy is refused
    pulse_reset("reset_before_timeout");
    for (int i = 0; i < 15; i++) step("timeout_wait", OP_LDA, 0, 0, 0, fetch_wait);
    step("timeout_expire", OP_LDA, 0, 0, 1, fetch_wait);
    step("timeout_halt", OP_LDA, 0, 0, 1, halt_err);
    step("timeout_hold", OP_LDA, 0, 0, 0, halt_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
